// File: rtl/shift_pkg.sv
// Shared constants for the iterative shift unit: opcodes, FSM encodings and default sizes.
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_stage_mux.sv
// One power-of-two shift stage: shifts value by 2^idx with the fill selected by opcode.
module shift_stage_mux
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] idx,
    input  logic [1:0]         opcode,
    output logic [WIDTH-1:0]   shifted
);

    logic [WIDTH-1:0] sll_v [SHAMT_W];
    logic [WIDTH-1:0] srl_v [SHAMT_W];
    logic [WIDTH-1:0] sra_v [SHAMT_W];

    // Every stage is a fixed-distance shift, so each is just wiring; only the final select is logic.
    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        assign sll_v[g] = value << (2 ** g);
        assign srl_v[g] = value >> (2 ** g);
        assign sra_v[g] = $signed(value) >>> (2 ** g);
    end

    always_comb begin
        shifted = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (idx == SHAMT_W'(i)) begin
                case (opcode)
                    OP_SRA:  shifted = sra_v[i];
                    OP_SRL:  shifted = srl_v[i];
                    default: shifted = sll_v[i];
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one power-of-two stage per cycle, MSB stage first, fixed latency.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; busy=0, done=0
// ST_SHIFT | applying stage idx_q each cycle; busy=1
// ST_DONE  | result valid, one-cycle done pulse; may accept a new start
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         opcode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               kill,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic [1:0]           op_q;
    logic [SHAMT_W-1:0]   idx_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept;
    logic                 last_stage;
    logic                 stage_take;
    logic [WIDTH-1:0]     stage_out;
    logic [WIDTH-1:0]     data_nx;

    shift_stage_mux #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .value   (data_q),
        .idx     (idx_q),
        .opcode  (op_q),
        .shifted (stage_out)
    );

    assign stage_take = |(shamt_q & (SHAMT_W'(1) << idx_q));
    assign data_nx    = stage_take ? stage_out : data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_stage = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (idx_q == '0) begin
                    last_stage = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start && !kill) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The final stage result goes straight into result_q so it is valid in the DONE cycle itself.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            data_q  <= data_in;
            shamt_q <= shamt;
            op_q    <= opcode;
            idx_q   <= SHAMT_W'(SHAMT_W - 1);
        end else if (state_q == ST_SHIFT && !kill) begin
            data_q <= data_nx;
            if (idx_q != '0) begin
                idx_q <= idx_q - 1'b1;
            end
            if (last_stage) begin
                result_q <= data_nx;
            end
        end
    end

    assign result = result_q;

endmodule
